// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// the NOP word used when IF/ID carries nothing, and word-size constants.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Redirect targets are captured word aligned; the low two bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// writes instruction + PC+4 into IF/ID, buffering one word across decode stalls.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instrOut,
  output logic [31:0] pcPlus4Out,
  output logic        ifidWrite,
  output logic        ifidFlush
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  target, target_next;
  logic [31:0]  instr_buf, instr_buf_next;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_addr;

  assign pc_plus4      = pc + WORD_BYTES;
  assign redirect_addr = align_word(redirectPc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      target    <= 32'h0;
      instr_buf <= NOP_INSTR;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      target    <= target_next;
      instr_buf <= instr_buf_next;
    end
  end

  // A request already issued cannot be withdrawn, so a redirect arriving while
  // a fetch is outstanding parks the new address in target (DRAIN) until the
  // stale ack arrives and its data is thrown away.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    target_next    = target;
    instr_buf_next = instr_buf;
    imemReq        = 1'b0;
    imemAddr       = pc;
    instrOut       = NOP_INSTR;
    pcPlus4Out     = 32'h0;
    ifidWrite      = 1'b0;
    ifidFlush      = 1'b0;

    if (reset) begin
      ifidFlush = redirect;
      case (state)
        FETCH: begin
          imemReq    = 1'b1;
          instrOut   = imemData;
          pcPlus4Out = pc_plus4;
          if (imemAck) begin
            if (redirect) begin
              pc_next = redirect_addr;
            end else if (stall) begin
              instr_buf_next = imemData;
              state_next     = HOLD;
            end else begin
              ifidWrite = 1'b1;
              pc_next   = pc_plus4;
            end
          end else if (redirect) begin
            target_next = redirect_addr;
            state_next  = DRAIN;
          end
        end

        HOLD: begin
          instrOut   = instr_buf;
          pcPlus4Out = pc_plus4;
          if (redirect) begin
            pc_next    = redirect_addr;
            state_next = FETCH;
          end else if (!stall) begin
            ifidWrite  = 1'b1;
            pc_next    = pc_plus4;
            state_next = FETCH;
          end
        end

        DRAIN: begin
          imemReq = 1'b1;
          if (imemAck) begin
            pc_next    = redirect ? redirect_addr : target;
            state_next = FETCH;
          end else if (redirect) begin
            target_next = redirect_addr;
          end
        end

        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized
// run against a transaction-level model of the fetch stream.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] instrOut;
  logic [31:0] pcPlus4Out;
  logic        ifidWrite;
  logic        ifidFlush;

  int checks = 0;
  int passed = 0;

  // Model: next address to fetch, whether a fetched word is parked waiting
  // for decode, and whether the outstanding request is a stale one.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_target = 32'h0;
  logic [31:0] m_buf = 32'h0;
  bit          m_held = 1'b0;
  bit          m_stale = 1'b0;

  bit          exp_req, exp_write, exp_flush, chk_addr, chk_payload;
  logic [31:0] exp_addr, exp_instr, exp_pc4;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirectPc(redirectPc), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData), .instrOut(instrOut),
    .pcPlus4Out(pcPlus4Out), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  // Drives one cycle of inputs, computes expected outputs from the model and
  // advances the model across the coming clock edge.
  task automatic step(input bit rst_n, input bit ack, input bit stl,
                      input bit red, input logic [31:0] rpc);
    logic [31:0] rpc_w;
    @(negedge clk);
    reset      = rst_n;
    stall      = stl;
    redirect   = red;
    redirectPc = rpc;
    imemAck    = ack;
    imemData   = ack ? mem_word(imemAddr) : $urandom;
    #1;
    rpc_w = {rpc[31:2], 2'b00};
    chk_addr = 1'b0;
    if (!rst_n) begin
      exp_req = 0; exp_write = 0; exp_flush = 0;
      exp_instr = 32'h0; exp_pc4 = 32'h0; exp_addr = 32'h0; chk_payload = 1;
    end else begin
      exp_flush = red;
      exp_pc4   = m_pc + 32'd4;
      if (m_held) begin
        exp_req = 0; exp_write = !stl && !red; exp_instr = m_buf; chk_payload = 1;
        exp_addr = m_pc;
      end else begin
        exp_req = 1; exp_addr = m_pc; chk_addr = 1;
        exp_write = !m_stale && ack && !stl && !red;
        exp_instr = mem_word(m_pc); chk_payload = exp_write;
      end
    end
    if (!rst_n) begin
      m_pc = 32'h0; m_target = 32'h0; m_buf = 32'h0; m_held = 0; m_stale = 0;
    end else if (m_held) begin
      if (red) begin m_pc = rpc_w; m_held = 0; end
      else if (!stl) begin m_pc = m_pc + 32'd4; m_held = 0; end
    end else if (m_stale) begin
      if (ack) begin m_pc = red ? rpc_w : m_target; m_stale = 0; end
      else if (red) m_target = rpc_w;
    end else if (ack) begin
      if (red) m_pc = rpc_w;
      else if (stl) begin m_buf = mem_word(m_pc); m_held = 1; end
      else m_pc = m_pc + 32'd4;
    end else if (red) begin
      m_target = rpc_w; m_stale = 1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 1'($urandom), 1'($urandom), 1, $urandom);
      checks++; if (imemReq !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", imemReq); else passed++;
      checks++; if (ifidWrite !== 1'b0) $display("[TB] FAIL reset_write: got %b expected 0", ifidWrite); else passed++;
      checks++; if (ifidFlush !== 1'b0) $display("[TB] FAIL reset_flush: got %b expected 0", ifidFlush); else passed++;
      checks++; if (instrOut !== 32'h0) $display("[TB] FAIL reset_instr: got %h expected 0", instrOut); else passed++;
      checks++; if (pcPlus4Out !== 32'h0) $display("[TB] FAIL reset_pc4: got %h expected 0", pcPlus4Out); else passed++;
    end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0);
      checks++; if (imemAddr !== 32'(i * 4)) $display("[TB] FAIL zw_addr: got %h expected %h", imemAddr, 32'(i * 4)); else passed++;
      checks++; if (ifidWrite !== 1'b1) $display("[TB] FAIL zw_write: got %b expected 1", ifidWrite); else passed++;
      checks++; if (pcPlus4Out !== 32'(i * 4 + 4)) $display("[TB] FAIL zw_pc4: got %h expected %h", pcPlus4Out, 32'(i * 4 + 4)); else passed++;
      checks++; if (instrOut !== mem_word(32'(i * 4))) $display("[TB] FAIL zw_instr: got %h expected %h", instrOut, mem_word(32'(i * 4))); else passed++;
    end
  endtask

  task automatic test_stall();
    step(1, 1, 1, 0, 0);
    checks++; if (imemAddr !== 32'h10) $display("[TB] FAIL st_addr: got %h expected 10", imemAddr); else passed++;
    checks++; if (ifidWrite !== 1'b0) $display("[TB] FAIL st_write_ack: got %b expected 0", ifidWrite); else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 0);
      checks++; if (imemReq !== 1'b0) $display("[TB] FAIL st_hold_req: got %b expected 0", imemReq); else passed++;
      checks++; if (ifidWrite !== 1'b0) $display("[TB] FAIL st_hold_write: got %b expected 0", ifidWrite); else passed++;
    end
    step(1, 0, 0, 0, 0);
    checks++; if (ifidWrite !== 1'b1) $display("[TB] FAIL st_rel_write: got %b expected 1", ifidWrite); else passed++;
    checks++; if (instrOut !== mem_word(32'h10)) $display("[TB] FAIL st_rel_instr: got %h expected %h", instrOut, mem_word(32'h10)); else passed++;
    checks++; if (pcPlus4Out !== 32'h14) $display("[TB] FAIL st_rel_pc4: got %h expected 14", pcPlus4Out); else passed++;
    checks++; if (imemReq !== 1'b0) $display("[TB] FAIL st_rel_req: got %b expected 0", imemReq); else passed++;
    step(1, 1, 0, 0, 0);
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h14) $display("[TB] FAIL st_next_addr: got req=%b addr=%h expected req=1 addr=14", imemReq, imemAddr); else passed++;
    checks++; if (pcPlus4Out !== 32'h18) $display("[TB] FAIL st_next_pc4: got %h expected 18", pcPlus4Out); else passed++;
  endtask

  task automatic test_latency();
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 3; c++) begin
        step(1, c == 2, 0, 0, 0);
        checks++; if (imemAddr !== 32'(32'h18 + w * 4)) $display("[TB] FAIL lat_addr: got %h expected %h", imemAddr, 32'(32'h18 + w * 4)); else passed++;
        checks++; if (ifidWrite !== (c == 2)) $display("[TB] FAIL lat_write: got %b expected %b", ifidWrite, c == 2); else passed++;
      end
    end
  endtask

  task automatic test_redirect_drain();
    step(1, 0, 0, 1, 32'h40);
    checks++; if (ifidFlush !== 1'b1) $display("[TB] FAIL dr_flush: got %b expected 1", ifidFlush); else passed++;
    checks++; if (imemAddr !== 32'h20) $display("[TB] FAIL dr_addr0: got %h expected 20", imemAddr); else passed++;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0);
      checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h20) $display("[TB] FAIL dr_wait: got req=%b addr=%h expected req=1 addr=20", imemReq, imemAddr); else passed++;
    end
    step(1, 1, 0, 0, 0);
    checks++; if (ifidWrite !== 1'b0) $display("[TB] FAIL dr_drop: got %b expected 0", ifidWrite); else passed++;
    step(1, 1, 0, 0, 0);
    checks++; if (imemAddr !== 32'h40) $display("[TB] FAIL dr_new_addr: got %h expected 40", imemAddr); else passed++;
    checks++; if (ifidWrite !== 1'b1 || pcPlus4Out !== 32'h44) $display("[TB] FAIL dr_first_write: got wr=%b pc4=%h expected wr=1 pc4=44", ifidWrite, pcPlus4Out); else passed++;
  endtask

  task automatic test_redirect_ack_stall();
    step(1, 1, 1, 1, 32'h103);
    checks++; if (ifidWrite !== 1'b0 || ifidFlush !== 1'b1) $display("[TB] FAIL ras_ctrl: got wr=%b fl=%b expected wr=0 fl=1", ifidWrite, ifidFlush); else passed++;
    step(1, 0, 0, 0, 0);
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) $display("[TB] FAIL ras_addr: got req=%b addr=%h expected req=1 addr=100", imemReq, imemAddr); else passed++;
  endtask

  task automatic test_wrap();
    step(1, 1, 0, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0, 0);
    checks++; if (imemAddr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_addr: got %h expected fffffffc", imemAddr); else passed++;
    checks++; if (ifidWrite !== 1'b1 || pcPlus4Out !== 32'h0) $display("[TB] FAIL wrap_pc4: got wr=%b pc4=%h expected wr=1 pc4=0", ifidWrite, pcPlus4Out); else passed++;
    step(1, 1, 0, 0, 0);
    checks++; if (imemAddr !== 32'h0) $display("[TB] FAIL wrap_next: got %h expected 0", imemAddr); else passed++;
  endtask

  task automatic test_reset_mid_drain();
    step(1, 0, 0, 1, 32'h80);
    step(1, 0, 0, 0, 0);
    checks++; if (imemAddr !== 32'h4) $display("[TB] FAIL rmd_old_addr: got %h expected 4", imemAddr); else passed++;
    step(0, 1, 0, 1, 32'h200);
    checks++; if (imemReq !== 1'b0 || ifidFlush !== 1'b0) $display("[TB] FAIL rmd_in_reset: got req=%b fl=%b expected 0 0", imemReq, ifidFlush); else passed++;
    step(1, 1, 0, 0, 0);
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) $display("[TB] FAIL rmd_restart: got req=%b addr=%h expected req=1 addr=0", imemReq, imemAddr); else passed++;
    checks++; if (ifidWrite !== 1'b1 || pcPlus4Out !== 32'h4) $display("[TB] FAIL rmd_write: got wr=%b pc4=%h expected wr=1 pc4=4", ifidWrite, pcPlus4Out); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(99) >= 2, $urandom_range(99) < 60, $urandom_range(99) < 25,
           $urandom_range(99) < 10, $urandom);
      checks++; if (imemReq !== exp_req) $display("[TB] FAIL rnd_req: cycle %0d got %b expected %b", i, imemReq, exp_req); else passed++;
      checks++; if (ifidWrite !== exp_write) $display("[TB] FAIL rnd_write: cycle %0d got %b expected %b", i, ifidWrite, exp_write); else passed++;
      checks++; if (ifidFlush !== exp_flush) $display("[TB] FAIL rnd_flush: cycle %0d got %b expected %b", i, ifidFlush, exp_flush); else passed++;
      if (chk_addr) begin
        checks++; if (imemAddr !== exp_addr) $display("[TB] FAIL rnd_addr: cycle %0d got %h expected %h", i, imemAddr, exp_addr); else passed++;
      end
      if (chk_payload) begin
        checks++; if (instrOut !== exp_instr) $display("[TB] FAIL rnd_instr: cycle %0d got %h expected %h", i, instrOut, exp_instr); else passed++;
        checks++; if (pcPlus4Out !== exp_pc4) $display("[TB] FAIL rnd_pc4: cycle %0d got %h expected %h", i, pcPlus4Out, exp_pc4); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_latency();
    test_redirect_drain();
    test_redirect_ack_stall();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues word requests to instruction memory over a req/ack handshake, and writes each fetched instruction plus its PC+4 into the IF/ID pipeline register. It is the writer side of IF/ID. It honours decode-stage stalls by buffering one instruction, and handles branch/jump redirects by flushing IF/ID and discarding in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- stall  in  1  IF/ID must not be written this cycle (hazard unit)
- redirect  in  1  branch/jump resolved taken this cycle
- redirectPc  in  32  new fetch address; bits[1:0] ignored (forced 0)
- imemReq  out  1  instruction memory request
- imemAddr  out  32  request address; stable while imemReq high and no ack
- imemAck  in  1  memory accepts the request; imemData valid this cycle
- imemData  in  32  fetched instruction word
- instrOut  out  32  instruction to IF/ID instrIn
- pcPlus4Out  out  32  PC+4 to IF/ID pcPlus4In
- ifidWrite  out  1  IF/ID write enable
- ifidFlush  out  1  IF/ID clear (drives IF/ID reset, inserting a NOP)

## Operation
- Registers: pc, target, instrBuf, state; state ∈ FETCH, HOLD, DRAIN.
- Priority per cycle: reset > redirect > stall.
- Reset (reset==0 at clk edge): pc=RESET_PC, state=FETCH, instrBuf=0, target=0. While reset is low: imemReq=0, ifidWrite=0, ifidFlush=0, instrOut=0, pcPlus4Out=0.
- FETCH: imemReq=1, imemAddr=pc.
  - ack, no redirect, no stall: ifidWrite=1, instrOut=imemData, pcPlus4Out=pc+4; pc<=pc+4; stay FETCH.
  - ack, stall: instrBuf<=imemData; go HOLD (pc unchanged).
  - ack, redirect: data discarded; pc<=redirectPc; stay FETCH.
  - no ack, redirect: target<=redirectPc; go DRAIN.
- HOLD: imemReq=0; instrOut=instrBuf, pcPlus4Out=pc+4.
  - no stall, no redirect: ifidWrite=1; pc<=pc+4; go FETCH.
  - redirect: buffer dropped; pc<=redirectPc; go FETCH.
- DRAIN: imemReq=1, imemAddr=pc (old address kept; handshake cannot be withdrawn).
  - ack: data discarded; pc<=target; go FETCH. Redirect in the same cycle: pc<=redirectPc.
  - redirect without ack: target<=redirectPc; stay DRAIN.
- ifidFlush = redirect (combinational, any state, not during reset); ifidWrite is 0 whenever redirect or stall is high.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0). redirectPc[1:0] are forced to 2'b00 on capture.

## Timing
- ifidWrite, instrOut, pcPlus4Out, ifidFlush are combinational from state and inputs (imemAck, imemData, stall, redirect). IF/ID captures them at the same edge.
- Zero-wait memory (ack in the cycle req rises): one instruction per cycle, with no bubbles.
- Latency from first request after reset to the first ifidWrite equals the memory ack delay. An ack in the first FETCH cycle gives ifidWrite in that cycle.
- Stall released from HOLD: write in the release cycle; the next fetch request is issued the following cycle (one bubble).
- Redirect: target address is presented on imemAddr in the next cycle from FETCH/HOLD. From DRAIN, it is presented in the cycle after the old ack.
- Stall held indefinitely in HOLD: no memory traffic, buffer retained.

## Structure
- Shared package: state encoding constants (FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2), NOP_INSTR=32'h0, WORD_BYTES=4.
- Single module; no sub-module is natural. The existing register_32 is not reused because it has a different reset style; pc, target and instrBuf are local registers.

## Test plan
- Reset, zero-wait memory returning addr-tagged words → imemAddr 0,4,8,…; ifidWrite every cycle; pcPlus4Out 4,8,12.
- 3-cycle ack latency → ifidWrite only in ack cycles; imemAddr held stable across each wait.
- Stall asserted at ack of addr 0x10 for 4 cycles → no write, imemReq=0 in HOLD; on release instrOut=word@0x10, pcPlus4Out=0x14; next request 0x14.
- Redirect to 0x40 while waiting on 0x20 (no ack) → ifidFlush=1 that cycle; imemAddr stays 0x20 until ack; data dropped; next request 0x40, and the first write has pcPlus4Out=0x44.
- Redirect to 0x103 in the same cycle as ack and stall → nothing written, ifidFlush=1; next imemAddr=0x100.
- PC at 0xFFFF_FFFC, ack → pcPlus4Out=0, next imemAddr=0. Reset low mid-DRAIN → next cycle imemAddr=RESET_PC, state FETCH.
